rf_exec_pipe_reg: RTL and testbench

Pipeline register between the RF-read stage and the execute stage of the 16-bit pipelined CPU. It sits directly downstream of the writeback-forwarding detector. It consumes the detector's RF-read-stage 2-bit match vector and the forwarded writeback value, and latches already-forwarded operands for execute. It also detects load-use hazards, which the writeback forwarding path cannot cover, and inserts one bubble per hazard while stalling upstream. It handles downstream hold and branch flush, and keeps a saturating bubble counter for performance debug.

---
 rtl/rf_exec_pipe_reg.sv | 109 ++++++++++
 tb/tb_rf_exec_pipe_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_exec_pipe_reg.sv
// RF-read -> execute pipeline register with operand forwarding select,
// load-use hazard bubble insertion, hold/flush handling and a saturating bubble counter.
module rf_exec_pipe_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [15:0]      i_ir,
  input  logic [15:0]      i_rx_data,
  input  logic [15:0]      i_ry_data,
  input  logic [1:0]       i_detect,
  input  logic [15:0]      i_fwd_data,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [15:0]      o_ir,
  output logic [15:0]      o_opa,
  output logic [15:0]      o_opb,
  output logic             o_stall_upstream,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  localparam logic [3:0] OP_MV_X   = 4'd0;
  localparam logic [3:0] OP_MVHI   = 4'd1;
  localparam logic [3:0] OP_ADD_X  = 4'd2;
  localparam logic [3:0] OP_SUB_X  = 4'd3;
  localparam logic [3:0] OP_LD     = 4'd4;
  localparam logic [3:0] OP_ST     = 4'd5;
  localparam logic [3:0] OP_CMP_X  = 4'd6;
  localparam logic [3:0] OP_J_X    = 4'd8;
  localparam logic [3:0] OP_JN_X   = 4'd9;
  localparam logic [3:0] OP_JZ_X   = 4'd10;
  localparam logic [3:0] OP_CALL_X = 4'd11;

  logic [3:0]  op;
  logic        imm;
  logic [2:0]  src_rx;
  logic [2:0]  src_ry;
  logic        reads_rx;
  logic        reads_ry;
  logic        hazard;
  logic [15:0] next_opa;
  logic [15:0] next_opb;
  logic        unused_ir_bits;

  assign op             = i_ir[3:0];
  assign imm            = i_ir[4];
  assign src_rx         = i_ir[7:5];
  assign src_ry         = i_ir[10:8];
  assign unused_ir_bits = ^i_ir[15:11];

  assign next_opa = i_detect[0] ? i_fwd_data : i_rx_data;
  assign next_opb = i_detect[1] ? i_fwd_data : i_ry_data;

  // Ry is a real source only in register form, except LD/ST which always address through it.
  always_comb begin
    reads_rx = 1'b0;
    reads_ry = 1'b0;
    case (op)
      OP_ADD_X, OP_SUB_X, OP_CMP_X: begin
        reads_rx = 1'b1;
        reads_ry = ~imm;
      end
      OP_ST: begin
        reads_rx = 1'b1;
        reads_ry = 1'b1;
      end
      OP_MVHI: reads_rx = 1'b1;
      OP_LD:   reads_ry = 1'b1;
      OP_MV_X, OP_J_X, OP_JN_X, OP_JZ_X, OP_CALL_X: reads_ry = ~imm;
      default: begin
        reads_rx = 1'b0;
        reads_ry = 1'b0;
      end
    endcase
  end

  assign hazard = o_valid && (o_ir[3:0] == OP_LD) && i_valid &&
                  ((reads_rx && (src_rx == o_ir[7:5])) ||
                   (reads_ry && (src_ry == o_ir[7:5])));

  assign o_stall_upstream = (i_stall | hazard) & ~i_flush;

  // The bubble clears o_valid, so a hazard never persists past one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid      <= 1'b0;
      o_ir         <= 16'h0000;
      o_opa        <= 16'h0000;
      o_opb        <= 16'h0000;
      o_bubble_cnt <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_stall) begin
      o_valid <= o_valid;
    end else if (hazard) begin
      o_valid <= 1'b0;
      if (o_bubble_cnt != {CNT_W{1'b1}})
        o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
    end else begin
      o_valid <= i_valid;
      o_ir    <= i_ir;
      o_opa   <= next_opa;
      o_opb   <= next_opb;
    end
  end

endmodule

// File: tb/tb_rf_exec_pipe_reg.sv
// Directed bench for rf_exec_pipe_reg: every-cycle comparison against a behavioural
// model plus hand-computed literal checks at key points of each scenario.
module tb_rf_exec_pipe_reg;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [3:0] OP_MV_X   = 4'd0;
  localparam logic [3:0] OP_MVHI   = 4'd1;
  localparam logic [3:0] OP_ADD_X  = 4'd2;
  localparam logic [3:0] OP_SUB_X  = 4'd3;
  localparam logic [3:0] OP_LD     = 4'd4;
  localparam logic [3:0] OP_ST     = 4'd5;
  localparam logic [3:0] OP_CMP_X  = 4'd6;
  localparam logic [3:0] OP_J_X    = 4'd8;
  localparam logic [3:0] OP_JN_X   = 4'd9;
  localparam logic [3:0] OP_JZ_X   = 4'd10;
  localparam logic [3:0] OP_CALL_X = 4'd11;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             i_valid = 1'b0;
  logic [15:0]      i_ir = '0;
  logic [15:0]      i_rx_data = '0;
  logic [15:0]      i_ry_data = '0;
  logic [1:0]       i_detect = '0;
  logic [15:0]      i_fwd_data = '0;
  logic             i_stall = 1'b0;
  logic             i_flush = 1'b0;
  logic             o_valid;
  logic [15:0]      o_ir;
  logic [15:0]      o_opa;
  logic [15:0]      o_opb;
  logic             o_stall_upstream;
  logic [CNT_W-1:0] o_bubble_cnt;

  int vectors = 0;
  int miscompares = 0;

  rf_exec_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_ir(i_ir),
    .i_rx_data(i_rx_data), .i_ry_data(i_ry_data), .i_detect(i_detect),
    .i_fwd_data(i_fwd_data), .i_stall(i_stall), .i_flush(i_flush),
    .o_valid(o_valid), .o_ir(o_ir), .o_opa(o_opa), .o_opb(o_opb),
    .o_stall_upstream(o_stall_upstream), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic imm,
                                     input logic [2:0] rx, input logic [2:0] ry);
    return {5'b00000, ry, rx, imm, op};
  endfunction

  // Which register fields an instruction really consumes, stated as opcode sets.
  function automatic bit uses_rx(input logic [15:0] ir);
    return ir[3:0] inside {OP_ADD_X, OP_SUB_X, OP_CMP_X, OP_ST, OP_MVHI};
  endfunction

  function automatic bit uses_ry(input logic [15:0] ir);
    if (ir[3:0] inside {OP_LD, OP_ST}) return 1'b1;
    return (ir[4] == 1'b0) &&
           (ir[3:0] inside {OP_MV_X, OP_ADD_X, OP_SUB_X, OP_CMP_X,
                            OP_J_X, OP_JN_X, OP_JZ_X, OP_CALL_X});
  endfunction

  logic        m_valid;
  logic [15:0] m_ir, m_opa, m_opb;
  int          m_cnt;
  bit          m_hazard;
  bit          m_stall_up;

  always_comb begin
    m_hazard = m_valid && (m_ir[3:0] == OP_LD) && i_valid &&
               ((uses_rx(i_ir) && i_ir[7:5] == m_ir[7:5]) ||
                (uses_ry(i_ir) && i_ir[10:8] == m_ir[7:5]));
    m_stall_up = !i_flush && (i_stall || m_hazard);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0; m_ir <= '0; m_opa <= '0; m_opb <= '0; m_cnt <= 0;
    end else if (i_flush) begin
      m_valid <= 1'b0;
    end else if (!i_stall) begin
      if (m_hazard) begin
        m_valid <= 1'b0;
        m_cnt   <= (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end else begin
        m_valid <= i_valid;
        m_ir    <= i_ir;
        m_opa   <= i_detect[0] ? i_fwd_data : i_rx_data;
        m_opb   <= i_detect[1] ? i_fwd_data : i_ry_data;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("valid", 32'(o_valid), 32'(m_valid));
    checkOutput("ir", 32'(o_ir), 32'(m_ir));
    checkOutput("opa", 32'(o_opa), 32'(m_opa));
    checkOutput("opb", 32'(o_opb), 32'(m_opb));
    checkOutput("stall_up", 32'(o_stall_upstream), 32'(m_stall_up));
    checkOutput("bubble_cnt", 32'(o_bubble_cnt), 32'(m_cnt));
  end

  task automatic applyStimulus(input logic v, input logic [15:0] ir, input logic [15:0] rx,
                               input logic [15:0] ry, input logic [1:0] det,
                               input logic [15:0] fwd, input logic stall, input logic flush);
    i_valid = v; i_ir = ir; i_rx_data = rx; i_ry_data = ry;
    i_detect = det; i_fwd_data = fwd; i_stall = stall; i_flush = flush;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, '0, '0, '0, 2'b00, '0, 1'b0, 1'b0);
    step(); step();
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_stall", 32'(o_stall_upstream), 32'd0);
    reset_n = 1'b1;

    applyStimulus(1'b1, mk(OP_ADD_X, 1'b0, 3'd1, 3'd2), 16'd5, 16'd7, 2'b01, 16'd9, 1'b0, 1'b0);
    step();
    checkOutput("fwd_rx_valid", 32'(o_valid), 32'd1);
    checkOutput("fwd_rx_opa", 32'(o_opa), 32'd9);
    checkOutput("fwd_rx_opb", 32'(o_opb), 32'd7);

    applyStimulus(1'b1, mk(OP_SUB_X, 1'b0, 3'd4, 3'd6), 16'd100, 16'd200, 2'b10, 16'h1234, 1'b0, 1'b0);
    step();
    checkOutput("fwd_ry_opa", 32'(o_opa), 32'd100);
    checkOutput("fwd_ry_opb", 32'(o_opb), 32'h1234);

    // Load-use: LD R3 followed by ADD reading R3.
    applyStimulus(1'b1, mk(OP_LD, 1'b0, 3'd3, 3'd4), 16'hAAAA, 16'h0040, 2'b00, '0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, mk(OP_ADD_X, 1'b0, 3'd3, 3'd5), 16'h0011, 16'h0022, 2'b00, '0, 1'b0, 1'b0);
    checkOutput("lu_stall", 32'(o_stall_upstream), 32'd1);
    step();
    checkOutput("lu_bubble_valid", 32'(o_valid), 32'd0);
    checkOutput("lu_bubble_cnt", 32'(o_bubble_cnt), 32'd1);
    checkOutput("lu_stall_fell", 32'(o_stall_upstream), 32'd0);
    step();
    checkOutput("lu_add_valid", 32'(o_valid), 32'd1);
    checkOutput("lu_add_ir", 32'(o_ir), 32'(mk(OP_ADD_X, 1'b0, 3'd3, 3'd5)));

    // Immediate form: Ry field equals the load target but is unused.
    applyStimulus(1'b1, mk(OP_LD, 1'b0, 3'd3, 3'd4), '0, '0, 2'b00, '0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, mk(OP_ADD_X, 1'b1, 3'd1, 3'd3), 16'd1, 16'd2, 2'b00, '0, 1'b0, 1'b0);
    checkOutput("imm_no_stall", 32'(o_stall_upstream), 32'd0);
    step();
    checkOutput("imm_valid", 32'(o_valid), 32'd1);
    checkOutput("imm_cnt", 32'(o_bubble_cnt), 32'd1);

    // Flush beats hazard.
    applyStimulus(1'b1, mk(OP_LD, 1'b0, 3'd3, 3'd4), 16'h0F0F, '0, 2'b00, '0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, mk(OP_ADD_X, 1'b0, 3'd3, 3'd5), '0, '0, 2'b00, '0, 1'b0, 1'b1);
    checkOutput("flush_stall", 32'(o_stall_upstream), 32'd0);
    step();
    checkOutput("flush_valid", 32'(o_valid), 32'd0);
    checkOutput("flush_cnt", 32'(o_bubble_cnt), 32'd1);
    checkOutput("flush_ir_hold", 32'(o_ir), 32'(mk(OP_LD, 1'b0, 3'd3, 3'd4)));

    // Stall hold for 3 cycles with changing inputs.
    applyStimulus(1'b1, mk(OP_MV_X, 1'b0, 3'd2, 3'd7), 16'h0101, 16'h0202, 2'b00, '0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, mk(OP_CMP_X, 1'b0, 3'(k), 3'(k + 1)), 16'(k + 16'h50), 16'(k + 16'h60),
                    2'(k), 16'hBEEF, 1'b1, 1'b0);
      checkOutput("stall_up", 32'(o_stall_upstream), 32'd1);
      step();
      checkOutput("stall_ir_hold", 32'(o_ir), 32'(mk(OP_MV_X, 1'b0, 3'd2, 3'd7)));
    end
    applyStimulus(1'b1, mk(OP_ST, 1'b0, 3'd6, 3'd1), 16'hCAFE, 16'hF00D, 2'b00, '0, 1'b0, 1'b0);
    step();
    checkOutput("release_ir", 32'(o_ir), 32'(mk(OP_ST, 1'b0, 3'd6, 3'd1)));
    checkOutput("release_opa", 32'(o_opa), 32'hCAFE);

    // Stall during hazard: no count until release.
    applyStimulus(1'b1, mk(OP_LD, 1'b0, 3'd5, 3'd0), '0, '0, 2'b00, '0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, mk(OP_ST, 1'b0, 3'd1, 3'd5), '0, '0, 2'b00, '0, 1'b1, 1'b0);
    step();
    checkOutput("stallhz_cnt", 32'(o_bubble_cnt), 32'd1);
    checkOutput("stallhz_valid", 32'(o_valid), 32'd1);
    applyStimulus(1'b1, mk(OP_ST, 1'b0, 3'd1, 3'd5), '0, '0, 2'b00, '0, 1'b0, 1'b0);
    step();
    checkOutput("stallhz_release_cnt", 32'(o_bubble_cnt), 32'd2);
    step();

    // Saturation: five more hazards.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, mk(OP_LD, 1'b0, 3'd2, 3'd0), '0, '0, 2'b00, '0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, mk(OP_MVHI, 1'b1, 3'd2, 3'd0), 16'(k), '0, 2'b00, '0, 1'b0, 1'b0);
      step(); step();
    end
    checkOutput("sat_cnt", 32'(o_bubble_cnt), 32'd3);

    // Async reset in the middle of a pending hazard.
    applyStimulus(1'b1, mk(OP_LD, 1'b0, 3'd2, 3'd0), 16'h7777, '0, 2'b00, '0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, mk(OP_ADD_X, 1'b0, 3'd2, 3'd0), '0, '0, 2'b00, '0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(o_valid), 32'd0);
    checkOutput("arst_ir", 32'(o_ir), 32'd0);
    checkOutput("arst_opa", 32'(o_opa), 32'd0);
    checkOutput("arst_cnt", 32'(o_bubble_cnt), 32'd0);
    checkOutput("arst_stall", 32'(o_stall_upstream), 32'd0);
    step();
    reset_n = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
